// File: rtl/ddr_arb_pkg.sv
// Shared types and default sizing for the DDR3 request-port arbiter.
package ddr_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_RD   = 2'd1,
        ARB_WR   = 2'd2
    } arb_state_t;

    localparam int unsigned RD_BURST_DEF        = 8;
    localparam int unsigned WR_BURST_DEF        = 8;
    localparam int unsigned MAX_RD_OUTSTANDING_DEF = 16;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/evt_counter.sv
// Saturating event counter with synchronous clear; clear has priority over counting.
module evt_counter #(
    parameter int unsigned MAX_COUNT = 8,
    parameter int unsigned CNT_W     = $clog2(MAX_COUNT + 1)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             evt,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (evt && (count_q < CNT_W'(MAX_COUNT))) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/ddr_burst_arbiter.sv
// Burst-based arbiter for the shared DDR3 request port: HDMI reads vs camera writes,
// with a credit limit on in-flight reads so the read-response FIFO cannot overflow.
module ddr_burst_arbiter
    import ddr_arb_pkg::*;
#(
    parameter int unsigned RD_BURST           = RD_BURST_DEF,
    parameter int unsigned WR_BURST           = WR_BURST_DEF,
    parameter int unsigned MAX_RD_OUTSTANDING = MAX_RD_OUTSTANDING_DEF,
    parameter int unsigned OUT_W              = $clog2(MAX_RD_OUTSTANDING + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rd_req_valid,
    input  logic             wr_req_valid,
    input  logic             mem_busy,
    input  logic             mem_complete,
    input  logic             complete_is_write,
    output logic             rd_grant,
    output logic             wr_grant,
    output logic             rd_issue,
    output logic             wr_issue,
    output logic [OUT_W-1:0] rd_outstanding,
    output logic [1:0]       arb_state
);

    localparam int unsigned BURST_MAX = max_u(RD_BURST, WR_BURST);
    localparam int unsigned CNT_W     = $clog2(BURST_MAX + 1);

    arb_state_t       state_q;
    arb_state_t       state_d;
    logic             burst_clr;
    logic [CNT_W-1:0] burst_cnt;
    logic [OUT_W-1:0] rd_out_q;
    logic [OUT_W-1:0] rd_out_d;
    logic             credit_ok;
    logic             rd_can;
    logic             rd_cpl;
    logic             rd_burst_end;
    logic             wr_burst_end;

    assign credit_ok    = rd_out_q < OUT_W'(MAX_RD_OUTSTANDING);
    assign rd_can       = rd_req_valid & credit_ok;
    assign rd_grant     = (state_q == ARB_RD);
    assign wr_grant     = (state_q == ARB_WR);
    assign rd_issue     = rd_grant & rd_can & ~mem_busy;
    assign wr_issue     = wr_grant & wr_req_valid & ~mem_busy;
    assign rd_burst_end = rd_issue & (burst_cnt == CNT_W'(RD_BURST - 1));
    assign wr_burst_end = wr_issue & (burst_cnt == CNT_W'(WR_BURST - 1));
    assign rd_cpl       = mem_complete & ~complete_is_write;

    // Next state; any exit from a grant (including re-entry into the same grant) restarts the burst count.
    always_comb begin
        state_d   = state_q;
        burst_clr = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (rd_can) begin
                    state_d   = ARB_RD;
                    burst_clr = 1'b1;
                end else if (wr_req_valid) begin
                    state_d   = ARB_WR;
                    burst_clr = 1'b1;
                end
            end
            ARB_RD: begin
                if (rd_burst_end || !rd_can) begin
                    burst_clr = 1'b1;
                    if (wr_req_valid)      state_d = ARB_WR;
                    else if (rd_req_valid) state_d = ARB_RD;
                    else                   state_d = ARB_IDLE;
                end
            end
            ARB_WR: begin
                if (wr_burst_end || !wr_req_valid) begin
                    burst_clr = 1'b1;
                    if (rd_can)            state_d = ARB_RD;
                    else if (wr_req_valid) state_d = ARB_WR;
                    else                   state_d = ARB_IDLE;
                end
            end
            default: begin
                state_d   = ARB_IDLE;
                burst_clr = 1'b1;
            end
        endcase
    end

    // In-flight reads; a stale completion after reset saturates at zero.
    always_comb begin
        rd_out_d = rd_out_q;
        if (rd_issue && !rd_cpl) begin
            rd_out_d = rd_out_q + OUT_W'(1);
        end else if (rd_cpl && !rd_issue && (rd_out_q != '0)) begin
            rd_out_d = rd_out_q - OUT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ARB_IDLE;
            rd_out_q <= '0;
        end else begin
            state_q  <= state_d;
            rd_out_q <= rd_out_d;
        end
    end

    evt_counter #(
        .MAX_COUNT (BURST_MAX),
        .CNT_W     (CNT_W)
    ) u_burst_cnt (
        .clk   (clk),
        .clr   (rst | burst_clr),
        .evt   (rd_issue | wr_issue),
        .count (burst_cnt)
    );

    assign rd_outstanding = rd_out_q;
    assign arb_state      = state_q;

endmodule
